zap_cache_maint_ctrl: RTL and testbench

Sequencer that turns a single CP15 cache/TLB maintenance command from the core into an ordered series of request/done handshakes toward the data cache, code cache and both TLBs. It sits between the core's maintenance outputs and the two cache instances. It guarantees write-back (clean) before invalidate, serialises steps, and reports completion or a watchdog timeout back to the core as one pulse.

---
 rtl/zap_cache_maint_ctrl_if.sv | 33 +++
 rtl/zap_cache_maint_ctrl.sv | 169 ++++++++++++++++
 tb/tb_zap_cache_maint_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_cache_maint_ctrl_if.sv
// Maintenance command and cache/TLB request bundle between the core, the
// sequencer and the cache instances.
interface zap_cache_maint_ctrl_if;
  logic       i_cmd_valid;
  logic [2:0] i_cmd;
  logic       o_cmd_ready;
  logic       o_cmd_done;
  logic       o_cmd_err;
  logic       o_dcache_clean;
  logic       i_dcache_clean_done;
  logic       o_dcache_inv;
  logic       i_dcache_inv_done;
  logic       o_icache_inv;
  logic       i_icache_inv_done;
  logic       o_dtlb_inv;
  logic       o_itlb_inv;

  modport slave (
    input  i_cmd_valid, i_cmd,
    input  i_dcache_clean_done, i_dcache_inv_done, i_icache_inv_done,
    output o_cmd_ready, o_cmd_done, o_cmd_err,
    output o_dcache_clean, o_dcache_inv, o_icache_inv,
    output o_dtlb_inv, o_itlb_inv
  );

  modport master (
    output i_cmd_valid, i_cmd,
    output i_dcache_clean_done, i_dcache_inv_done, i_icache_inv_done,
    input  o_cmd_ready, o_cmd_done, o_cmd_err,
    input  o_dcache_clean, o_dcache_inv, o_icache_inv,
    input  o_dtlb_inv, o_itlb_inv
  );
endinterface

// File: rtl/zap_cache_maint_ctrl.sv
// Sequences one CP15 maintenance command into ordered clean/invalidate
// handshakes toward both caches and TLBs, with a per-step watchdog.
module zap_cache_maint_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4096
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  zap_cache_maint_ctrl_if.slave  bus
);

  localparam int unsigned MASK_W     = 5;
  localparam int unsigned TIMER_W    = 32;
  localparam int unsigned STEP_CLEAN = 4;
  localparam int unsigned STEP_INV   = 3;
  localparam int unsigned STEP_IC    = 2;
  localparam int unsigned STEP_DTLB  = 1;
  localparam int unsigned STEP_ITLB  = 0;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMEOUT_CYCLES - TIMER_W'(1);
  localparam logic               WD_EN      = (TIMEOUT_CYCLES != '0);

  typedef enum logic [2:0] {
    S_IDLE, S_DC_CLEAN, S_DC_INV, S_IC_INV, S_TLB, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                err_q, err_d;

  logic ready_q, ready_d;
  logic done_q, done_d;
  logic cmd_err_q, cmd_err_d;
  logic clean_q, clean_d;
  logic inv_q, inv_d;
  logic ic_q, ic_d;
  logic dtlb_q, dtlb_d;
  logic itlb_q, itlb_d;

  logic              req_done;
  logic [MASK_W-1:0] cur_bit;
  logic              expire;

  function automatic logic [MASK_W-1:0] decode(input logic [2:0] cmd);
    logic [MASK_W-1:0] m;
    m = '0;
    unique case (cmd)
      3'd1: m[STEP_CLEAN] = 1'b1;
      3'd2: m[STEP_INV]   = 1'b1;
      3'd3: begin m[STEP_CLEAN] = 1'b1; m[STEP_INV] = 1'b1; end
      3'd4: m[STEP_IC]    = 1'b1;
      3'd5: m[STEP_DTLB]  = 1'b1;
      3'd6: m[STEP_ITLB]  = 1'b1;
      3'd7: m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Fixed step order; cleared mask bits are skipped without spending a cycle.
  function automatic state_e first_step(input logic [MASK_W-1:0] m);
    if (m[STEP_CLEAN])                   return S_DC_CLEAN;
    else if (m[STEP_INV])                return S_DC_INV;
    else if (m[STEP_IC])                 return S_IC_INV;
    else if (m[STEP_DTLB] | m[STEP_ITLB]) return S_TLB;
    else                                 return S_DONE;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      clean_q   <= 1'b0;
      inv_q     <= 1'b0;
      ic_q      <= 1'b0;
      dtlb_q    <= 1'b0;
      itlb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      cmd_err_q <= cmd_err_d;
      clean_q   <= clean_d;
      inv_q     <= inv_d;
      ic_q      <= ic_d;
      dtlb_q    <= dtlb_d;
      itlb_q    <= itlb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    timer_d  = timer_q;
    err_d    = err_q;
    req_done = 1'b0;
    cur_bit  = '0;
    expire   = WD_EN && (timer_q == TIMER_LAST);

    unique case (state_q)
      S_DC_CLEAN: begin req_done = bus.i_dcache_clean_done; cur_bit[STEP_CLEAN] = 1'b1; end
      S_DC_INV:   begin req_done = bus.i_dcache_inv_done;   cur_bit[STEP_INV]   = 1'b1; end
      S_IC_INV:   begin req_done = bus.i_icache_inv_done;   cur_bit[STEP_IC]    = 1'b1; end
      default:    ;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          mask_d  = decode(bus.i_cmd);
          state_d = first_step(mask_d);
        end
      end
      S_DC_CLEAN, S_DC_INV, S_IC_INV: begin
        // A done in the expiry cycle still completes the step cleanly.
        if (req_done) begin
          mask_d  = mask_q & ~cur_bit;
          state_d = first_step(mask_d);
        end else if (expire) begin
          mask_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_TLB: begin
        mask_d  = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    done_d    = (state_d == S_DONE);
    cmd_err_d = (state_d == S_DONE) && err_d;
    clean_d   = (state_d == S_DC_CLEAN);
    inv_d     = (state_d == S_DC_INV);
    ic_d      = (state_d == S_IC_INV);
    dtlb_d    = (state_d == S_TLB) && mask_d[STEP_DTLB];
    itlb_d    = (state_d == S_TLB) && mask_d[STEP_ITLB];
  end

  assign bus.o_cmd_ready    = ready_q;
  assign bus.o_cmd_done     = done_q;
  assign bus.o_cmd_err      = cmd_err_q;
  assign bus.o_dcache_clean = clean_q;
  assign bus.o_dcache_inv   = inv_q;
  assign bus.o_icache_inv   = ic_q;
  assign bus.o_dtlb_inv     = dtlb_q;
  assign bus.o_itlb_inv     = itlb_q;

endmodule

// File: tb/tb_zap_cache_maint_ctrl.sv
// Directed bench: builds per-cycle stimulus and expected outputs from the
// command rules, then checks the controller every cycle.
module tb_zap_cache_maint_ctrl;

  localparam logic [31:0] TO  = 32'd8;
  localparam int          TOI = 8;

  localparam int B_READY = 7, B_DONE = 6, B_ERR = 5, B_CLEAN = 4;
  localparam int B_INV = 3, B_IC = 2, B_DTLB = 1, B_ITLB = 0;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [2:0] cmd;
    logic [2:0] dn;   // {clean_done, inv_done, icache_done}
  } stim_t;

  typedef struct packed {
    logic       chk;
    logic [7:0] v;    // {ready, done, err, clean, inv, ic, dtlb, itlb}
  } exp_t;

  typedef struct {
    int    cyc;
    int    bp;
    logic  val;
    string name;
  } pin_t;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  zap_cache_maint_ctrl_if bus ();

  zap_cache_maint_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  stim_t stim_q[$];
  exp_t  exp_q[$];
  pin_t  pins[$];
  int    errors = 0;
  int    checks = 0;
  logic       busy_valid = 1'b0;
  logic [2:0] busy_cmd   = 3'd0;

  task automatic push(input stim_t s, input logic chk, input logic [7:0] v);
    exp_t e;
    e.chk = chk;
    e.v   = v;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic add_pin(input int c, input int bp, input logic val, input string name);
    pins.push_back('{c, bp, val, name});
  endtask

  function automatic stim_t busy_stim();
    stim_t s;
    s = '0;
    s.valid = busy_valid;
    s.cmd   = busy_cmd;
    return s;
  endfunction

  task automatic add_idle(input int n, input logic noise);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = '0;
      s.dn = noise ? 3'b111 : 3'b000;
      push(s, 1'b1, 8'h80);
    end
  endtask

  // Model of one command: lat = cycle (1-based) of the step's done, 0 = never.
  task automatic add_cmd(input logic [2:0] cmd, input int lc, input int li,
                         input int lic, input bit spur);
    stim_t s;
    bit    need [3];
    int    lat  [3];
    bit    dt, it, err, abort, timed;
    int    n;
    logic [7:0] v;
    need[0] = (cmd == 3'd1) || (cmd == 3'd3) || (cmd == 3'd7);
    need[1] = (cmd == 3'd2) || (cmd == 3'd3) || (cmd == 3'd7);
    need[2] = (cmd == 3'd4) || (cmd == 3'd7);
    dt      = (cmd == 3'd5) || (cmd == 3'd7);
    it      = (cmd == 3'd6) || (cmd == 3'd7);
    lat[0] = lc; lat[1] = li; lat[2] = lic;
    err = 0; abort = 0;
    s = '0; s.valid = 1'b1; s.cmd = cmd;
    push(s, 1'b1, 8'h80);
    for (int k = 0; k < 3; k++) begin
      if (need[k] && !abort) begin
        timed = (lat[k] == 0) || (lat[k] > TOI);
        n     = timed ? TOI : lat[k];
        for (int c = 1; c <= n; c++) begin
          s = busy_stim();
          if (!timed && c == n) s.dn[2-k] = 1'b1;
          if (spur) s.dn = s.dn | ~(3'b100 >> k);
          v = '0;
          v[B_CLEAN-k] = 1'b1;
          push(s, 1'b1, v);
        end
        if (timed) begin abort = 1; err = 1; end
      end
    end
    if (!abort && (dt || it)) begin
      v = '0; v[B_DTLB] = dt; v[B_ITLB] = it;
      push(busy_stim(), 1'b1, v);
    end
    v = '0; v[B_DONE] = 1'b1; v[B_ERR] = err;
    push(busy_stim(), 1'b1, v);
  endtask

  // FULL_FLUSH with a slow clean; reset lands in cycle 2 of the command.
  task automatic add_reset_mid();
    stim_t s;
    int b;
    b = stim_q.size();
    s = '0; s.valid = 1'b1; s.cmd = 3'd7;
    push(s, 1'b1, 8'h80);
    push(busy_stim(), 1'b1, 8'h10);
    s = '0; s.rst = 1'b1;
    push(s, 1'b1, 8'h10);
    push('0, 1'b1, 8'h00);
    add_idle(2, 1'b0);
    add_pin(b + 3, B_CLEAN, 1'b0, "reset_drops_clean");
    add_pin(b + 3, B_DONE,  1'b0, "reset_no_done");
    add_pin(b + 4, B_READY, 1'b1, "ready_after_reset");
  endtask

  task automatic check(input int i);
    logic [7:0] act;
    act = {bus.o_cmd_ready, bus.o_cmd_done, bus.o_cmd_err, bus.o_dcache_clean,
           bus.o_dcache_inv, bus.o_icache_inv, bus.o_dtlb_inv, bus.o_itlb_inv};
    if (exp_q[i].chk) begin
      checks++;
      if (act !== exp_q[i].v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got rdy/done/err/cln/inv/ic/dtlb/itlb=%b want %b",
                 i, act, exp_q[i].v);
      end
    end
    foreach (pins[p]) begin
      if (pins[p].cyc == i) begin
        checks++;
        if (act[pins[p].bp] !== pins[p].val) begin
          errors++;
          $display("FAIL %s cycle %0d: got %b want %b", pins[p].name, i,
                   act[pins[p].bp], pins[p].val);
        end
      end
    end
  endtask

  task automatic apply(input stim_t s);
    rst                     = s.rst;
    bus.i_cmd_valid         = s.valid;
    bus.i_cmd               = s.cmd;
    bus.i_dcache_clean_done = s.dn[2];
    bus.i_dcache_inv_done   = s.dn[1];
    bus.i_icache_inv_done   = s.dn[0];
  endtask

  initial begin
    stim_t s;
    int b;

    // Power-on reset: outputs unknown before the first edge.
    s = '0; s.rst = 1'b1;
    push(s, 1'b0, 8'h00);
    push(s, 1'b1, 8'h00);
    push('0, 1'b1, 8'h00);
    add_idle(1, 1'b0);
    add_idle(1, 1'b1);
    add_pin(3, B_READY, 1'b1, "ready_after_por");

    b = stim_q.size();
    add_cmd(3'd3, 3, 2, 0, 0);
    add_pin(b + 3, B_CLEAN, 1'b1, "clean_inv_clean_c3");
    add_pin(b + 4, B_CLEAN, 1'b0, "clean_inv_clean_c4");
    add_pin(b + 4, B_INV,   1'b1, "clean_inv_inv_c4");
    add_pin(b + 6, B_DONE,  1'b1, "clean_inv_done_c6");
    add_pin(b + 6, B_ERR,   1'b0, "clean_inv_err_c6");
    add_pin(b + 7, B_READY, 1'b1, "clean_inv_ready_c7");

    b = stim_q.size();
    add_cmd(3'd7, 1, 1, 1, 0);
    add_pin(b + 1, B_CLEAN, 1'b1, "flush_clean_c1");
    add_pin(b + 2, B_INV,   1'b1, "flush_inv_c2");
    add_pin(b + 3, B_IC,    1'b1, "flush_ic_c3");
    add_pin(b + 4, B_DTLB,  1'b1, "flush_dtlb_c4");
    add_pin(b + 4, B_ITLB,  1'b1, "flush_itlb_c4");
    add_pin(b + 5, B_DONE,  1'b1, "flush_done_c5");

    b = stim_q.size();
    add_cmd(3'd4, 0, 0, 0, 0);
    add_pin(b + 8, B_IC,   1'b1, "ic_timeout_req_c8");
    add_pin(b + 9, B_IC,   1'b0, "ic_timeout_drop_c9");
    add_pin(b + 9, B_DONE, 1'b1, "ic_timeout_done_c9");
    add_pin(b + 9, B_ERR,  1'b1, "ic_timeout_err_c9");

    b = stim_q.size();
    add_cmd(3'd7, 1, 1, 0, 0);
    add_pin(b + 11, B_ERR,  1'b1, "flush_ic_timeout_err");
    add_pin(b + 11, B_ITLB, 1'b0, "flush_itlb_abandoned");

    b = stim_q.size();
    busy_valid = 1'b1; busy_cmd = 3'd5;
    add_cmd(3'd0, 0, 0, 0, 0);
    busy_valid = 1'b0; busy_cmd = 3'd0;
    add_cmd(3'd5, 0, 0, 0, 0);
    add_pin(b + 1, B_DONE, 1'b1, "nop_done_c1");
    add_pin(b + 3, B_DTLB, 1'b1, "dtlb_pulse_c3");
    add_pin(b + 3, B_ITLB, 1'b0, "dtlb_no_itlb_c3");
    add_pin(b + 4, B_DONE, 1'b1, "dtlb_done_c4");

    b = stim_q.size();
    add_cmd(3'd1, 4, 0, 0, 1);
    add_pin(b + 2, B_CLEAN, 1'b1, "spurious_inv_done_ignored");

    b = stim_q.size();
    add_cmd(3'd4, 0, 0, 8, 0);
    add_pin(b + 9, B_ERR, 1'b0, "done_at_expiry_wins");

    add_cmd(3'd2, 0, 9, 0, 0);
    add_cmd(3'd6, 0, 0, 0, 0);
    add_cmd(3'd1, 1, 0, 0, 0);
    add_cmd(3'd2, 0, 1, 0, 0);
    add_idle(1, 1'b1);
    add_reset_mid();

    apply(stim_q[0]);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i > 0) apply(stim_q[i]);
      @(negedge clk);
      check(i);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
